// File: rtl/rob_lite.sv
// rtl/rob_lite.sv - two-wide allocate, in-order commit reorder buffer
// Optional ROB_DUAL_COMMIT_EN retires the two oldest completed entries per cycle.
module rob_lite #(
    parameter int ROB_DEPTH    = 16,
    parameter int L_ADDR_WIDTH = 5,
    parameter int P_ADDR_WIDTH = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_request_1,
    input  logic                         valid_request_2,
    input  logic [L_ADDR_WIDTH-1:0]      lreg_1,
    input  logic [L_ADDR_WIDTH-1:0]      lreg_2,
    input  logic [P_ADDR_WIDTH-1:0]      preg_1,
    input  logic [P_ADDR_WIDTH-1:0]      preg_2,
    input  logic [P_ADDR_WIDTH-1:0]      old_preg_1,
    input  logic [P_ADDR_WIDTH-1:0]      old_preg_2,
    output logic [$clog2(ROB_DEPTH)-1:0] rob_id_1,
    output logic [$clog2(ROB_DEPTH)-1:0] rob_id_2,
    output logic                         is_full,
    output logic                         two_empty,
    input  logic                         wb_valid,
    input  logic [$clog2(ROB_DEPTH)-1:0] wb_rob_id,
    output logic                         commit_valid_1,
    output logic                         commit_valid_2,
    output logic [L_ADDR_WIDTH-1:0]      commit_lreg_1,
    output logic [L_ADDR_WIDTH-1:0]      commit_lreg_2,
    output logic [P_ADDR_WIDTH-1:0]      commit_preg_1,
    output logic [P_ADDR_WIDTH-1:0]      commit_preg_2,
    output logic [P_ADDR_WIDTH-1:0]      commit_old_preg_1,
    output logic [P_ADDR_WIDTH-1:0]      commit_old_preg_2,
    input  logic                         commit_ready,
    input  logic                         flush_valid
);

    localparam int IDX_W = $clog2(ROB_DEPTH);
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ROB_DEPTH);

    logic [IDX_W:0]          head_q;
    logic [IDX_W:0]          tail_q;
    logic [IDX_W:0]          count_q;
    logic [ROB_DEPTH-1:0]    valid_q;
    logic [ROB_DEPTH-1:0]    done_q;
    logic [L_ADDR_WIDTH-1:0] lreg_q     [ROB_DEPTH];
    logic [P_ADDR_WIDTH-1:0] preg_q     [ROB_DEPTH];
    logic [P_ADDR_WIDTH-1:0] old_preg_q [ROB_DEPTH];

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [IDX_W-1:0] tail_idx_p1;
    logic             alloc_1;
    logic             alloc_2;
    logic             commit_1;
    logic             commit_2;
    logic [IDX_W:0]   alloc_cnt;
    logic [IDX_W:0]   commit_cnt;
    logic             unused_wrap;

    assign head_idx    = head_q[IDX_W-1:0];
    assign tail_idx    = tail_q[IDX_W-1:0];
    assign tail_idx_p1 = tail_idx + IDX_W'(1);
    // Wrap bits only keep pointer arithmetic honest; occupancy comes from count_q.
    assign unused_wrap = head_q[IDX_W] ^ tail_q[IDX_W];

    assign rob_id_1  = tail_idx;
    assign rob_id_2  = tail_idx_p1;
    assign is_full   = (count_q == FULL_CNT);
    assign two_empty = ((FULL_CNT - count_q) >= (IDX_W+1)'(2));

    // Slot 2 only rides along with slot 1, so allocation stays contiguous.
    assign alloc_1   = valid_request_1 && !is_full;
    assign alloc_2   = valid_request_1 && valid_request_2 && two_empty;
    assign alloc_cnt = (IDX_W+1)'(alloc_1) + (IDX_W+1)'(alloc_2);

    assign commit_1 = !flush_valid && commit_ready && valid_q[head_idx] && done_q[head_idx];

`ifdef ROB_DUAL_COMMIT_EN
    logic [IDX_W-1:0] head_idx_p1;
    assign head_idx_p1       = head_idx + IDX_W'(1);
    assign commit_2          = commit_1 && valid_q[head_idx_p1] && done_q[head_idx_p1];
    assign commit_lreg_2     = lreg_q[head_idx_p1];
    assign commit_preg_2     = preg_q[head_idx_p1];
    assign commit_old_preg_2 = old_preg_q[head_idx_p1];
`else
    assign commit_2          = 1'b0;
    assign commit_lreg_2     = '0;
    assign commit_preg_2     = '0;
    assign commit_old_preg_2 = '0;
`endif

    assign commit_cnt        = (IDX_W+1)'(commit_1) + (IDX_W+1)'(commit_2);
    assign commit_valid_1    = commit_1;
    assign commit_valid_2    = commit_2;
    assign commit_lreg_1     = lreg_q[head_idx];
    assign commit_preg_1     = preg_q[head_idx];
    assign commit_old_preg_1 = old_preg_q[head_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else if (flush_valid) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            // Later assignments win: allocation overrides writeback on the same index.
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (wb_valid && wb_rob_id == IDX_W'(i) && valid_q[i]) begin
                    done_q[i] <= 1'b1;
                end
                if ((commit_1 && head_idx == IDX_W'(i)) ||
                    (commit_2 && head_idx + IDX_W'(1) == IDX_W'(i))) begin
                    valid_q[i] <= 1'b0;
                    done_q[i]  <= 1'b0;
                end
                if ((alloc_1 && tail_idx == IDX_W'(i)) ||
                    (alloc_2 && tail_idx_p1 == IDX_W'(i))) begin
                    valid_q[i] <= 1'b1;
                    done_q[i]  <= 1'b0;
                end
            end
            head_q  <= head_q + commit_cnt;
            tail_q  <= tail_q + alloc_cnt;
            count_q <= count_q + alloc_cnt - commit_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_1 && !flush_valid) begin
            lreg_q[tail_idx]     <= lreg_1;
            preg_q[tail_idx]     <= preg_1;
            old_preg_q[tail_idx] <= old_preg_1;
        end
        if (alloc_2 && !flush_valid) begin
            lreg_q[tail_idx_p1]     <= lreg_2;
            preg_q[tail_idx_p1]     <= preg_2;
            old_preg_q[tail_idx_p1] <= old_preg_2;
        end
    end

endmodule

// File: tb/tb_rob_lite.sv
// tb/tb_rob_lite.sv - directed self-checking bench for rob_lite
module tb_rob_lite;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_request_1 = 1'b0, valid_request_2 = 1'b0;
    logic [4:0] lreg_1 = '0, lreg_2 = '0;
    logic [6:0] preg_1 = '0, preg_2 = '0, old_preg_1 = '0, old_preg_2 = '0;
    logic [3:0] rob_id_1, rob_id_2;
    logic       is_full, two_empty;
    logic       wb_valid = 1'b0;
    logic [3:0] wb_rob_id = '0;
    logic       commit_valid_1, commit_valid_2;
    logic [4:0] commit_lreg_1, commit_lreg_2;
    logic [6:0] commit_preg_1, commit_preg_2, commit_old_preg_1, commit_old_preg_2;
    logic       commit_ready = 1'b0;
    logic       flush_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    rob_lite dut (
        .clk(clk), .rst(rst),
        .valid_request_1(valid_request_1), .valid_request_2(valid_request_2),
        .lreg_1(lreg_1), .lreg_2(lreg_2), .preg_1(preg_1), .preg_2(preg_2),
        .old_preg_1(old_preg_1), .old_preg_2(old_preg_2),
        .rob_id_1(rob_id_1), .rob_id_2(rob_id_2),
        .is_full(is_full), .two_empty(two_empty),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id),
        .commit_valid_1(commit_valid_1), .commit_valid_2(commit_valid_2),
        .commit_lreg_1(commit_lreg_1), .commit_lreg_2(commit_lreg_2),
        .commit_preg_1(commit_preg_1), .commit_preg_2(commit_preg_2),
        .commit_old_preg_1(commit_old_preg_1), .commit_old_preg_2(commit_old_preg_2),
        .commit_ready(commit_ready), .flush_valid(flush_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] fl(input int t); return 5'(t + 3);  endfunction
    function automatic logic [6:0] fp(input int t); return 7'(t + 64); endfunction
    function automatic logic [6:0] fo(input int t); return 7'(t + 32); endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v1, input logic v2, input int t1, input int t2);
        valid_request_1 = v1;
        valid_request_2 = v2;
        lreg_1 = fl(t1); preg_1 = fp(t1); old_preg_1 = fo(t1);
        lreg_2 = fl(t2); preg_2 = fp(t2); old_preg_2 = fo(t2);
        tick();
        valid_request_1 = 1'b0;
        valid_request_2 = 1'b0;
    endtask

    task automatic wb(input int t);
        wb_valid  = 1'b1;
        wb_rob_id = 4'(t);
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic flush;
        flush_valid = 1'b1;
        tick();
        flush_valid = 1'b0;
    endtask

    int tags[4] = '{14, 15, 0, 1};
    int n;

    initial begin
        #3;
        check_eq("rst_is_full", is_full, 0);
        check_eq("rst_two_empty", two_empty, 1);
        check_eq("rst_commit_valid_1", commit_valid_1, 0);
        check_eq("rst_commit_valid_2", commit_valid_2, 0);
        check_eq("rst_rob_id_1", rob_id_1, 0);
        check_eq("rst_rob_id_2", rob_id_2, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // lone slot-2 request is ignored
        req(1'b0, 1'b1, 0, 0);
        check_eq("v2_alone_tail", rob_id_1, 0);

        // fill with 16 singles
        for (int i = 0; i < 16; i++) begin
            check_eq("fill_rob_id_1", rob_id_1, 32'(i));
            if (i == 14) check_eq("fill14_two_empty", two_empty, 1);
            if (i == 15) check_eq("fill15_two_empty", two_empty, 0);
            if (i == 15) check_eq("fill15_is_full", is_full, 0);
            req(1'b1, 1'b0, i, 0);
        end
        check_eq("full_is_full", is_full, 1);
        check_eq("full_two_empty", two_empty, 0);
        check_eq("full_tail", rob_id_1, 0);
        req(1'b1, 1'b0, 20, 0);
        check_eq("overfill_tail", rob_id_1, 0);
        check_eq("overfill_is_full", is_full, 1);
        flush();
        check_eq("flush1_is_full", is_full, 0);

        // 15 entries then dual request: slot 1 only
        for (int i = 0; i < 15; i++) req(1'b1, 1'b0, i, 0);
        check_eq("fill15_rob_id_1", rob_id_1, 15);
        check_eq("fill15b_two_empty", two_empty, 0);
        req(1'b1, 1'b1, 15, 16);
        check_eq("dual_at15_is_full", is_full, 1);
        check_eq("dual_at15_tail", rob_id_1, 0);
        flush();

        // 8 entries, flush with concurrent dual request and done head
        for (int k = 0; k < 4; k++) begin
            check_eq("dual_rob_id_2", rob_id_2, 32'(2 * k + 1));
            req(1'b1, 1'b1, 2 * k, 2 * k + 1);
        end
        check_eq("eight_rob_id_1", rob_id_1, 8);
        wb(0);
        check_eq("held_no_commit", commit_valid_1, 0);
        flush_valid = 1'b1; commit_ready = 1'b1;
        valid_request_1 = 1'b1; valid_request_2 = 1'b1;
        #1;
        check_eq("flush_forces_commit_0", commit_valid_1, 0);
        tick();
        flush_valid = 1'b0; commit_ready = 1'b0;
        valid_request_1 = 1'b0; valid_request_2 = 1'b0;
        check_eq("post_flush_two_empty", two_empty, 1);
        check_eq("post_flush_is_full", is_full, 0);
        check_eq("post_flush_rob_id_1", rob_id_1, 0);
        check_eq("post_flush_commit", commit_valid_1, 0);

        // in-order commit; writeback to an invalid entry is dropped
        wb(0);
        commit_ready = 1'b1;
        wb_valid = 1'b1; wb_rob_id = 4'd1;
        req(1'b1, 1'b1, 0, 1);
        wb_valid = 1'b0;
        req(1'b1, 1'b0, 2, 0);
        check_eq("stale_wb_ignored", commit_valid_1, 0);
        wb(2);
        check_eq("young_done_waits", commit_valid_1, 0);
        wb(0);
        check_eq("c0_valid", commit_valid_1, 1);
        check_eq("c0_lreg", commit_lreg_1, fl(0));
        check_eq("c0_preg", commit_preg_1, fp(0));
        check_eq("c0_old", commit_old_preg_1, fo(0));
        check_eq("c0_valid_2", commit_valid_2, 0);
        tick();
        check_eq("tag1_blocks", commit_valid_1, 0);
        wb(1);
        check_eq("c1_valid", commit_valid_1, 1);
        check_eq("c1_lreg", commit_lreg_1, fl(1));
`ifdef ROB_DUAL_COMMIT_EN
        check_eq("c1_valid_2", commit_valid_2, 1);
        check_eq("c1_lreg_2", commit_lreg_2, fl(2));
        tick();
`else
        check_eq("c1_valid_2", commit_valid_2, 0);
        tick();
        check_eq("c2_valid", commit_valid_1, 1);
        check_eq("c2_old", commit_old_preg_1, fo(2));
        tick();
`endif
        check_eq("drained_35", commit_valid_1, 0);
        check_eq("tail_35", rob_id_1, 3);

        // commit_ready backpressure
        commit_ready = 1'b0;
        req(1'b1, 1'b0, 3, 0);
        wb(3);
        check_eq("bp_hold_a", commit_valid_1, 0);
        tick();
        check_eq("bp_hold_b", commit_valid_1, 0);
        commit_ready = 1'b1;
        #1;
        check_eq("bp_release", commit_valid_1, 1);
        check_eq("bp_release_preg", commit_preg_1, fp(3));
        tick();
        check_eq("bp_done", commit_valid_1, 0);

        // wrap: bring head=tail=14 then allocate 4
        flush();
        commit_ready = 1'b0;
        for (int k = 0; k < 7; k++) req(1'b1, 1'b1, 2 * k, 2 * k + 1);
        for (int k = 0; k < 14; k++) wb(k);
        commit_ready = 1'b1;
        #1;
        n = 0;
        while (commit_valid_1 && n < 40) begin
            tick();
            n++;
        end
        check_eq("drain_in_budget", 32'(n < 40), 1);
        check_eq("wrap_start_tail", rob_id_1, 14);
        commit_ready = 1'b0;
        req(1'b1, 1'b1, 14, 15);
        req(1'b1, 1'b1, 0, 1);
        check_eq("wrap_tail", rob_id_1, 2);
        for (int k = 0; k < 4; k++) wb(tags[k]);
        commit_ready = 1'b1;
        #1;
`ifdef ROB_DUAL_COMMIT_EN
        for (int j = 0; j < 2; j++) begin
            check_eq("wrap_cv1", commit_valid_1, 1);
            check_eq("wrap_cv2", commit_valid_2, 1);
            check_eq("wrap_lreg_1", commit_lreg_1, fl(tags[2 * j]));
            check_eq("wrap_lreg_2", commit_lreg_2, fl(tags[2 * j + 1]));
            tick();
        end
`else
        for (int j = 0; j < 4; j++) begin
            check_eq("wrap_cv1", commit_valid_1, 1);
            check_eq("wrap_cv2", commit_valid_2, 0);
            check_eq("wrap_lreg_1", commit_lreg_1, fl(tags[j]));
            tick();
        end
`endif
        check_eq("wrap_empty", commit_valid_1, 0);
        check_eq("wrap_two_empty", two_empty, 1);

        // asynchronous reset mid-operation
        req(1'b1, 1'b1, 2, 3);
        wb(2);
        check_eq("pre_rst_commit", commit_valid_1, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("async_rst_commit", commit_valid_1, 0);
        check_eq("async_rst_rob_id_1", rob_id_1, 0);
        check_eq("async_rst_two_empty", two_empty, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        check_eq("after_rst_commit", commit_valid_1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_lite.md
ROB_LITE -- requirements
Module: rob_lite

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, number of entries (power of two, >=4).
REQ-002 SHALL have parameter L_ADDR_WIDTH, default 5, logical register index width.
REQ-003 SHALL have parameter P_ADDR_WIDTH, default 7, physical register index width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 valid_request_1 / valid_request_2  in  1 each  allocation requests from rename, slot 1 older than slot 2.
REQ-007 lreg_1 / lreg_2  in  L_ADDR_WIDTH  logical destination per request.
REQ-008 preg_1 / preg_2  in  P_ADDR_WIDTH  new physical destination per request.
REQ-009 old_preg_1 / old_preg_2  in  P_ADDR_WIDTH  previous mapping, freed at commit.
REQ-010 rob_id_1 / rob_id_2  out  log2(ROB_DEPTH)  tags for slot 1/2 this cycle (tail, tail+1).
REQ-011 is_full  out  1  no free entries; two_empty  out  1  at least two free entries.
REQ-012 wb_valid  in  1; wb_rob_id  in  log2(ROB_DEPTH)  execution-complete marking.
REQ-013 commit_valid_1/2  out  1; commit_lreg_1/2, commit_preg_1/2, commit_old_preg_1/2  out  widths as above; commit_ready  in  1.
REQ-014 flush_valid  in  1  discard all in-flight entries.

Function
REQ-015 Circular buffer, head/tail pointers with one extra wrap bit, count register 0..ROB_DEPTH.
REQ-016 is_full = (count == ROB_DEPTH); two_empty = (ROB_DEPTH - count >= 2); both from registered count only, no same-cycle bypass of commits.
REQ-017 Invariant: is_full implies !two_empty.
REQ-018 Slot 1 allocates at tail when valid_request_1 and !is_full; slot 2 at tail+1 when valid_request_2, valid_request_1 and two_empty.
REQ-019 valid_request_2 without valid_request_1, or with !two_empty, SHALL be ignored (no allocation, no error state).
REQ-020 Allocated entry: valid=1, done=0, fields captured; tail advances by accepted count (0/1/2), wrapping mod ROB_DEPTH.
REQ-021 wb_valid sets done on entry wb_rob_id next edge; writeback to invalid entry ignored.
REQ-022 Writeback and allocation to same index in one cycle: allocation wins (done=0).
REQ-023 commit_valid_1 = head valid && head done && commit_ready; outputs driven combinationally from head entry.
REQ-024 On commit, entry invalidated, head+1, count decremented; latency writeback-to-commit-eligible = 1 cycle.
REQ-025 Simultaneous allocate and commit: count updates by (allocated - committed) same edge.
REQ-026 flush_valid: all entries invalid, head=tail=0, count=0 next edge; overrides same-cycle allocate, writeback, commit; commit_valid_1/2 forced 0 that cycle.

Reset
REQ-027 rst SHALL clear head, tail, count, all valid/done bits immediately, regardless of clock.
REQ-028 Reset values: is_full=0, two_empty=1, commit_valid_1/2=0, rob_id_1=0, rob_id_2=1.
REQ-029 Reset asserted mid-operation drops all pending entries; no commit emitted in reset.

Configuration
REQ-030 Macro ROB_DUAL_COMMIT_EN.
REQ-031 Defined: commit_valid_2 = commit_valid_1 && head+1 valid && done; both retire same edge, head+2.
REQ-032 Undefined: commit_valid_2 tied 0, commit_*_2 tied 0, max one commit per cycle.

Verification
REQ-033 Reset then 16 single allocations, no writeback -> is_full=1, two_empty=0 after 16th edge; 17th request ignored, tail unchanged.
REQ-034 15 entries allocated, dual request -> only slot 1 accepted, count=16, rob_id_1=15.
REQ-035 Allocate tags 0,1,2; writeback 2 then 0 -> commit only tag 0 (in-order), tag 2 waits for tag 1.
REQ-036 commit_ready=0 with done head -> commit_valid_1=0, count held; raise -> commit next cycle.
REQ-037 Flush with 8 entries plus same-cycle dual request -> count=0, two_empty=1, no commits, next allocation rob_id_1=0.
REQ-038 Wrap: head=tail=14, allocate 4, complete all -> tags 14,15,0,1 commit in order (two per cycle with ROB_DUAL_COMMIT_EN, else one).
